pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
// Central sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
// Generates per-stage enable/flush from debug-unit commands (run, single step, clear),
// the halt flag retiring at WB, load-use stall and taken-branch flush.
// Counts executed cycles for the debug unit. Sits between debug unit, hazard unit and datapath.
// PARAMETERS
// CNT_W  32  width of o_cycle_count
// PORTS
// Clock           in   1      system clock, all state on rising edge
// i_reset_n       in   1      synchronous reset, active low
// i_run           in   1      level: continuous execution requested
// i_step          in   1      pulse: execute exactly one pipeline cycle
// i_debug_clear   in   1      pulse: leave HALTED, flush pipeline, clear counter
// i_halt_wb       in   1      halt flag at MEM/WB output (halt instr reached WB)
// i_load_use      in   1      load-use hazard detected in ID
// i_branch_taken  in   1      branch/jump resolved taken in ID
// o_pc_enable     out  1      PC write enable
// o_ifid_enable   out  1      IF/ID enable;   o_ifid_flush   out 1  IF/ID flush
// o_idex_enable   out  1      ID/EX enable;   o_idex_flush   out 1  ID/EX flush
// o_exmem_enable  out  1      EX/MEM enable;  o_exmem_flush  out 1  EX/MEM flush
// o_memwb_enable  out  1      MEM/WB enable;  o_memwb_flush  out 1  MEM/WB flush
// o_busy          out  1      1 in RUN or STEP
// o_halted        out  1      1 in HALTED
// o_cycle_count   out  CNT_W  number of advance cycles since reset/clear
// BEHAVIOUR
// - One clock (Clock); reset synchronous, active low (i_reset_n). State/counter regs; outputs combinational.
// - While i_reset_n=0: all flushes=1, all enables=0, busy=halted=0; next state IDLE, count=0.
// - States: IDLE=2'b00, RUN=2'b01, STEP=2'b10, HALTED=2'b11.
//   IDLE:   i_run -> RUN; else i_step -> STEP (run wins if both).
//   RUN:    i_halt_wb -> HALTED; else !i_run -> IDLE; else stay.
//   STEP:   i_halt_wb -> HALTED; else -> IDLE (always exactly one cycle).
//   HALTED: i_debug_clear -> IDLE; i_run/i_step ignored.
// - adv = (state==RUN || state==STEP) && !i_halt_wb.
// - IDLE, HALTED, or halt cycle (i_halt_wb in RUN/STEP): all enables=0, all flushes=0 (freeze).
// - adv, no hazard: all enables=1, all flushes=0.
// - adv && i_load_use: pc=0, ifid_en=0, idex_en=1 with idex_flush=1 (bubble), exmem/memwb en=1.
// - adv && i_branch_taken && !i_load_use: all enables=1, ifid_flush=1.
// - load_use + branch same cycle: stall wins, branch ignored (ID re-evaluates next cycle).
// - Cycle with i_debug_clear in HALTED: all flushes=1, enables=0; count cleared next edge.
//   i_debug_clear in other states: ignored.
// - o_cycle_count: +1 on each edge where adv=1 (stall cycles included); saturates at all-ones.
// - Halt cycle does not count. Reset mid-RUN: IDLE next edge, no carry-over.
// TESTING
// - Reset, i_run=1 for 10 cycles -> all enables=1 each cycle, o_busy=1, o_cycle_count=10.
// - IDLE, i_step pulse x3 -> 3 single cycles of enables=1, back to IDLE each time, count=3.
// - RUN, i_load_use=1 one cycle -> pc/ifid_en=0, idex_flush=1, exmem/memwb_en=1; count still +1.
// - RUN, i_load_use=1 & i_branch_taken=1 -> stall pattern, ifid_flush=0.
// - RUN, i_halt_wb=1 at cycle 7 -> enables=0 that cycle, HALTED, count=6.
//   i_step ignored; i_debug_clear -> flushes=1 one cycle, IDLE, count=0.
// - CNT_W=4, run 20 cycles -> count saturates at 4'hF.
// - i_reset_n=0 during RUN -> flushes=1, enables=0 immediately; IDLE after edge.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: turns debug-unit commands, WB halt and ID hazards into
// per-stage enable/flush strobes for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
module pipeline_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             Clock,
   input  logic             i_reset_n,
   input  logic             i_run,
   input  logic             i_step,
   input  logic             i_debug_clear,
   input  logic             i_halt_wb,
   input  logic             i_load_use,
   input  logic             i_branch_taken,
   output logic             o_pc_enable,
   output logic             o_ifid_enable,
   output logic             o_ifid_flush,
   output logic             o_idex_enable,
   output logic             o_idex_flush,
   output logic             o_exmem_enable,
   output logic             o_exmem_flush,
   output logic             o_memwb_enable,
   output logic             o_memwb_flush,
   output logic             o_busy,
   output logic             o_halted,
   output logic [CNT_W-1:0] o_cycle_count
);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      RUN    = 2'b01,
      STEP   = 2'b10,
      HALTED = 2'b11
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cycle_count;
   logic             active;
   logic             adv;
   logic             clear_req;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // A halt reaching WB freezes the pipe in the very cycle it is seen.
   always_comb begin
      active    = i_reset_n && (state == RUN || state == STEP);
      adv       = active && !i_halt_wb;
      clear_req = i_reset_n && (state == HALTED) && i_debug_clear;
   end

   always_ff @(posedge Clock) begin
      if (!i_reset_n) begin
         state       <= IDLE;
         cycle_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (i_run)
                  state <= RUN;
               else if (i_step)
                  state <= STEP;
            end
            RUN: begin
               if (i_halt_wb)
                  state <= HALTED;
               else if (!i_run)
                  state <= IDLE;
            end
            STEP: begin
               if (i_halt_wb)
                  state <= HALTED;
               else
                  state <= IDLE;
            end
            HALTED: begin
               if (i_debug_clear)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         if (clear_req)
            cycle_count <= '0;
         else if (adv && cycle_count != CNT_MAX)
            cycle_count <= cycle_count + CNT_ONE;
      end
   end

   // Load-use stall holds PC and IF/ID and injects a bubble into ID/EX;
   // it takes priority over a taken branch, which ID re-resolves next cycle.
   always_comb begin
      o_pc_enable    = 1'b0;
      o_ifid_enable  = 1'b0;
      o_idex_enable  = 1'b0;
      o_exmem_enable = 1'b0;
      o_memwb_enable = 1'b0;
      o_ifid_flush   = 1'b0;
      o_idex_flush   = 1'b0;
      o_exmem_flush  = 1'b0;
      o_memwb_flush  = 1'b0;

      if (!i_reset_n || clear_req) begin
         o_ifid_flush  = 1'b1;
         o_idex_flush  = 1'b1;
         o_exmem_flush = 1'b1;
         o_memwb_flush = 1'b1;
      end else if (adv) begin
         o_exmem_enable = 1'b1;
         o_memwb_enable = 1'b1;
         o_idex_enable  = 1'b1;
         if (i_load_use) begin
            o_idex_flush = 1'b1;
         end else begin
            o_pc_enable   = 1'b1;
            o_ifid_enable = 1'b1;
            o_ifid_flush  = i_branch_taken;
         end
      end
   end

   assign o_busy        = active;
   assign o_halted      = i_reset_n && (state == HALTED);
   assign o_cycle_count = cycle_count;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized scoreboard bench for pipeline_ctrl: a behavioural model queues the
// expected strobes for every cycle and an independent monitor checks them.
module tb_pipeline_ctrl;

   logic        Clock = 1'b0;
   logic        i_reset_n = 1'b0;
   logic        i_run = 1'b0, i_step = 1'b0, i_debug_clear = 1'b0;
   logic        i_halt_wb = 1'b0, i_load_use = 1'b0, i_branch_taken = 1'b0;

   logic        pc_en, ifid_en, ifid_fl, idex_en, idex_fl;
   logic        exmem_en, exmem_fl, memwb_en, memwb_fl, busy, halted;
   logic [31:0] count32;

   logic        s_pc_en, s_ifid_en, s_ifid_fl, s_idex_en, s_idex_fl;
   logic        s_exmem_en, s_exmem_fl, s_memwb_en, s_memwb_fl, s_busy, s_halted;
   logic [3:0]  count4;

   always #5 Clock = ~Clock;

   pipeline_ctrl dut (
      .Clock(Clock), .i_reset_n(i_reset_n), .i_run(i_run), .i_step(i_step),
      .i_debug_clear(i_debug_clear), .i_halt_wb(i_halt_wb),
      .i_load_use(i_load_use), .i_branch_taken(i_branch_taken),
      .o_pc_enable(pc_en), .o_ifid_enable(ifid_en), .o_ifid_flush(ifid_fl),
      .o_idex_enable(idex_en), .o_idex_flush(idex_fl),
      .o_exmem_enable(exmem_en), .o_exmem_flush(exmem_fl),
      .o_memwb_enable(memwb_en), .o_memwb_flush(memwb_fl),
      .o_busy(busy), .o_halted(halted), .o_cycle_count(count32)
   );

   pipeline_ctrl #(.CNT_W(4)) dut_small (
      .Clock(Clock), .i_reset_n(i_reset_n), .i_run(i_run), .i_step(i_step),
      .i_debug_clear(i_debug_clear), .i_halt_wb(i_halt_wb),
      .i_load_use(i_load_use), .i_branch_taken(i_branch_taken),
      .o_pc_enable(s_pc_en), .o_ifid_enable(s_ifid_en), .o_ifid_flush(s_ifid_fl),
      .o_idex_enable(s_idex_en), .o_idex_flush(s_idex_fl),
      .o_exmem_enable(s_exmem_en), .o_exmem_flush(s_exmem_fl),
      .o_memwb_enable(s_memwb_en), .o_memwb_flush(s_memwb_fl),
      .o_busy(s_busy), .o_halted(s_halted), .o_cycle_count(count4)
   );

   typedef struct {
      logic [4:0] en;
      logic [3:0] fl;
      logic       busy;
      logic       halted;
      longint     cnt;
   } exp_t;

   exp_t exp_q[$];
   int   compared = 0;
   int   mismatched = 0;

   // Reference model: debug mode as a name plus an unbounded advance counter.
   localparam int MODE_IDLE = 0, MODE_RUN = 1, MODE_STEP = 2, MODE_HALTED = 3;
   int     mode = MODE_IDLE;
   longint model_cnt = 0;

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      compared++;
      if (actual != expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic rst_n, input logic run, input logic step,
                                input logic clr, input logic halt, input logic lu,
                                input logic br);
      exp_t e;
      bit   executing, advancing, clearing;
      @(posedge Clock);
      #1;
      i_reset_n = rst_n; i_run = run; i_step = step; i_debug_clear = clr;
      i_halt_wb = halt; i_load_use = lu; i_branch_taken = br;

      executing = rst_n && (mode == MODE_RUN || mode == MODE_STEP);
      advancing = executing && !halt;
      clearing  = rst_n && mode == MODE_HALTED && clr;
      e.busy    = executing;
      e.halted  = rst_n && mode == MODE_HALTED;
      e.en      = 5'b00000;
      e.fl      = 4'b0000;
      if (!rst_n || clearing) e.fl = 4'b1111;
      else if (advancing) begin
         if (lu) begin
            e.en = 5'b00111;
            e.fl = 4'b0100;
         end else begin
            e.en = 5'b11111;
            e.fl = {br, 3'b000};
         end
      end
      e.cnt = model_cnt;
      exp_q.push_back(e);

      if (!rst_n) begin
         mode = MODE_IDLE;
         model_cnt = 0;
      end else begin
         if (clearing) model_cnt = 0;
         else if (advancing) model_cnt++;
         if (mode == MODE_IDLE) mode = run ? MODE_RUN : (step ? MODE_STEP : MODE_IDLE);
         else if (mode == MODE_RUN) mode = halt ? MODE_HALTED : (run ? MODE_RUN : MODE_IDLE);
         else if (mode == MODE_STEP) mode = halt ? MODE_HALTED : MODE_IDLE;
         else if (clr) mode = MODE_IDLE;
      end
   endtask

   // Monitor: compares whatever the DUTs present against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge Clock);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("enables", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, e.en);
            checkOutput("flushes", {ifid_fl, idex_fl, exmem_fl, memwb_fl}, e.fl);
            checkOutput("busy", busy, e.busy);
            checkOutput("halted", halted, e.halted);
            checkOutput("count32", count32, (e.cnt > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : e.cnt);
            checkOutput("count4", count4, (e.cnt > 15) ? 15 : e.cnt);
            checkOutput("small_enables", {s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en}, e.en);
            checkOutput("small_flags", {s_ifid_fl, s_idex_fl, s_exmem_fl, s_memwb_fl, s_busy, s_halted},
                        {e.fl, e.busy, e.halted});
         end
      end
   end

   initial begin
      logic run_lvl;
      int   guard;
      $display("[TB] start");
      repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0);
      repeat (11) applyStimulus(1, 1, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 0, 1, 0, 0, 0, 0);
         applyStimulus(1, 0, 0, 0, 0, 0, 0);
         applyStimulus(1, 0, 0, 0, 0, 0, 0);
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      for (int i = 1; i <= 7; i++)
         applyStimulus(1, 1, 0, 0, i == 7, i == 3, i == 3 || i == 5);
      applyStimulus(1, 1, 1, 0, 0, 0, 0);
      applyStimulus(1, 0, 1, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 1, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      repeat (22) applyStimulus(1, 1, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0);

      run_lvl = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 9) == 0) run_lvl = ~run_lvl;
         applyStimulus($urandom_range(0, 79) != 0, run_lvl,
                       $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0,
                       $urandom_range(0, 14) == 0, $urandom_range(0, 4) == 0,
                       $urandom_range(0, 3) == 0);
      end

      guard = 0;
      while (exp_q.size() > 0 && guard < 20) begin
         @(posedge Clock);
         guard++;
      end
      if (exp_q.size() > 0) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
